bin2prio_arb: RTL and testbench

- Registered, parametrised successor to the combinational priority selector.
- Selects one request from a DW-bit request vector in either fixed-priority mode (highest index wins) or round-robin mode (rotating priority pointer).
- Locks the grant until the consumer acknowledges it.
- Sits between request sources and a shared resource; provides one-hot and binary grant outputs with a valid/ack handshake.

---
 rtl/bin2prio_arb_if.sv | 15 +
 rtl/bin2prio_arb.sv | 88 ++++++++
 tb/tb_bin2prio_arb.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/bin2prio_arb_if.sv
// Request/grant bundle between request sources, the arbiter and the grant consumer.
interface bin2prio_arb_if #(
  parameter int DW = 64,
  parameter int IW = (DW > 1) ? $clog2(DW) : 1
);
  logic [DW-1:0] req;
  logic          ack;
  logic [DW-1:0] gnt;
  logic [IW-1:0] gnt_idx;
  logic          valid;
  logic [15:0]   busy_cnt;

  modport master (output req, ack, input gnt, gnt_idx, valid, busy_cnt);
  modport slave  (input req, ack, output gnt, gnt_idx, valid, busy_cnt);
endinterface

// File: rtl/bin2prio_arb.sv
// Registered fixed-priority / round-robin arbiter with a grant held until acknowledged.
module bin2prio_arb #(
  parameter  int DW   = 64,
  parameter  int MODE = 0,
  localparam int IW   = (DW > 1) ? $clog2(DW) : 1
) (
  input logic           clk,
  input logic           rst,
  bin2prio_arb_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] p_eval;
  logic [IW-1:0] pick;
  logic          hit;
  int            idx;

  // In GRANT the pointer is evaluated as if the pending ack were already applied,
  // so back-to-back arbitration sees the rotated priority on the same edge.
  always_comb begin
    p_eval = IW'(DW - 1);
    if (MODE == 1) begin
      p_eval = ptr;
      if (state == GRANT)
        p_eval = (bus.gnt_idx == '0) ? IW'(DW - 1) : bus.gnt_idx - IW'(1);
    end
  end

  // Descending scan from p_eval, wrapping through DW-1.
  always_comb begin
    pick = '0;
    hit  = 1'b0;
    idx  = 0;
    for (int k = 0; k < DW; k++) begin
      idx = int'(p_eval) - k;
      if (idx < 0) idx = idx + DW;
      if (!hit && bus.req[idx]) begin
        hit  = 1'b1;
        pick = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bus.gnt      <= '0;
      bus.gnt_idx  <= '0;
      bus.valid    <= 1'b0;
      bus.busy_cnt <= '0;
      ptr          <= IW'(DW - 1);
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state        <= GRANT;
            bus.gnt      <= DW'(1) << pick;
            bus.gnt_idx  <= pick;
            bus.valid    <= 1'b1;
            bus.busy_cnt <= '0;
          end
        end
        GRANT: begin
          if (bus.ack) begin
            ptr <= p_eval;
            if (hit) begin
              bus.gnt      <= DW'(1) << pick;
              bus.gnt_idx  <= pick;
              bus.busy_cnt <= '0;
            end else begin
              state        <= IDLE;
              bus.gnt      <= '0;
              bus.gnt_idx  <= '0;
              bus.valid    <= 1'b0;
            end
          end else if (bus.busy_cnt != 16'hFFFF) begin
            bus.busy_cnt <= bus.busy_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2prio_arb.sv
// Directed bench: DUT a is DW=8 fixed priority, DUT b is DW=8 round-robin.
module tb_bin2prio_arb;
  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  bin2prio_arb_if #(.DW(8)) if_a ();
  bin2prio_arb_if #(.DW(8)) if_b ();

  bin2prio_arb #(.DW(8), .MODE(0)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  bin2prio_arb #(.DW(8), .MODE(1)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_a(input string tag, input logic v, input logic [7:0] g, input logic [2:0] i);
    chk({tag, ".valid"}, 32'(if_a.valid), 32'(v));
    chk({tag, ".gnt"}, 32'(if_a.gnt), 32'(g));
    chk({tag, ".idx"}, 32'(if_a.gnt_idx), 32'(i));
    chk({tag, ".onehot"}, 32'($countones(if_a.gnt)), 32'(if_a.valid));
  endtask

  task automatic exp_b(input string tag, input logic v, input logic [7:0] g, input logic [2:0] i);
    chk({tag, ".valid"}, 32'(if_b.valid), 32'(v));
    chk({tag, ".gnt"}, 32'(if_b.gnt), 32'(g));
    chk({tag, ".idx"}, 32'(if_b.gnt_idx), 32'(i));
    chk({tag, ".onehot"}, 32'($countones(if_b.gnt)), 32'(if_b.valid));
  endtask

  initial begin
    logic [2:0] seq2 [8];
    seq2 = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};

    rst = 1'b1;
    if_a.req = '0; if_a.ack = 1'b0;
    if_b.req = '0; if_b.ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    exp_a("rst_a", 1'b0, 8'h00, 3'd0);
    exp_b("rst_b", 1'b0, 8'h00, 3'd0);
    chk("rst_a.busy", 32'(if_a.busy_cnt), 32'd0);
    tick();
    exp_a("idle_a", 1'b0, 8'h00, 3'd0);

    // fixed priority: highest index wins, busy counts, re-grant of same requester
    if_a.req = 8'b0010_0110;
    tick();
    exp_a("t1_grant", 1'b1, 8'h20, 3'd5);
    chk("t1_busy0", 32'(if_a.busy_cnt), 32'd0);
    tick(); tick(); tick();
    exp_a("t1_hold", 1'b1, 8'h20, 3'd5);
    chk("t1_busy3", 32'(if_a.busy_cnt), 32'd3);
    if_a.ack = 1'b1;
    tick();
    exp_a("t1_regrant", 1'b1, 8'h20, 3'd5);
    chk("t1_busy_clr", 32'(if_a.busy_cnt), 32'd0);
    if_a.req = 8'b1000_0001;
    tick();
    exp_a("t1_top", 1'b1, 8'h80, 3'd7);
    if_a.req = '0;
    tick();
    exp_a("t1_idle", 1'b0, 8'h00, 3'd0);
    if_a.ack = 1'b0;

    // round-robin two requesters: 7,0,7,0
    if_b.req = 8'b1000_0001;
    tick();
    exp_b("t3_g0", 1'b1, 8'h80, 3'd7);
    if_b.ack = 1'b1;
    tick();
    exp_b("t3_g1", 1'b1, 8'h01, 3'd0);
    tick();
    exp_b("t3_g2", 1'b1, 8'h80, 3'd7);
    tick();
    exp_b("t3_g3", 1'b1, 8'h01, 3'd0);
    if_b.req = '0;
    tick();
    exp_b("t3_idle", 1'b0, 8'h00, 3'd0);
    if_b.ack = 1'b0;

    // round-robin all requesting: 7 then 6..0 and wrap to 7
    if_b.req = 8'hFF;
    tick();
    exp_b("t2_first", 1'b1, 8'h80, 3'd7);
    if_b.ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_b($sformatf("t2_seq%0d", k), 1'b1, 8'(8'h01 << seq2[k]), seq2[k]);
    end

    // lock: ptr is 7, ack consumes 7 and picks 3; grant then ignores req changes
    if_b.req = 8'b0000_1000;
    tick();
    exp_b("t4_grant3", 1'b1, 8'h08, 3'd3);
    if_b.ack = 1'b0;
    if_b.req = 8'b1000_0000;
    tick(); tick();
    exp_b("t4_lock", 1'b1, 8'h08, 3'd3);
    if_b.ack = 1'b1;
    if_b.req = '0;
    tick();
    exp_b("t4_release", 1'b0, 8'h00, 3'd0);

    // ptr is now 2; grants 7 then 6, hold 6, reset between edges
    if_b.req = 8'b1000_0000;
    if_b.ack = 1'b0;
    tick();
    exp_b("t5_g7", 1'b1, 8'h80, 3'd7);
    if_b.ack = 1'b1;
    if_b.req = 8'b0100_0000;
    tick();
    exp_b("t5_g6", 1'b1, 8'h40, 3'd6);
    if_b.ack = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    exp_b("t5_async", 1'b0, 8'h00, 3'd0);
    tick();
    rst = 1'b0;
    if_b.req = 8'hFF;
    tick();
    exp_b("t5_after", 1'b1, 8'h80, 3'd7);

    // saturation of busy_cnt on the fixed-priority instance
    if_a.req = 8'h01;
    tick();
    exp_a("t6_grant", 1'b1, 8'h01, 3'd0);
    repeat (65534) @(posedge clk);
    #1;
    chk("t6_busy_fffe", 32'(if_a.busy_cnt), 32'h0000_FFFE);
    repeat (10) @(posedge clk);
    #1;
    chk("t6_busy_sat", 32'(if_a.busy_cnt), 32'h0000_FFFF);
    exp_a("t6_hold", 1'b1, 8'h01, 3'd0);
    if_a.ack = 1'b1;
    if_a.req = 8'h02;
    tick();
    exp_a("t6_new", 1'b1, 8'h02, 3'd1);
    chk("t6_busy_clr", 32'(if_a.busy_cnt), 32'd0);
    if_a.req = '0;
    tick();
    exp_a("t6_idle", 1'b0, 8'h00, 3'd0);
    tick();
    exp_a("t6_ack_idle", 1'b0, 8'h00, 3'd0);
    chk("t6_ack_idle.busy", 32'(if_a.busy_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
